// File: rtl/vga_driver.sv
// vga_driver: 640x480@60 VGA timing generator with pixel request/position
// outputs and an RGB565 output gate.
// Optional build macro VGA_TEST_PATTERN_EN replaces pixel_data with eight
// full-scale vertical colour bars inside the active window.
module vga_driver #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_en,
  output logic [15:0] vga_rgb,
  output logic        data_req,
  output logic [9:0]  pixel_xpos,
  output logic [9:0]  pixel_ypos,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [9:0] H_LAST    = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_DISP);
  localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_DISP);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  logic       v_win;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  // Horizontal counter: free-running over the whole line.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  h_cnt <= '0;
    else if (h_end)  h_cnt <= '0;
    else             h_cnt <= h_cnt + 10'd1;
  end

  // Vertical counter: advances on the last pixel of each line.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) v_cnt <= '0;
    else if (h_end) v_cnt <= v_end ? '0 : v_cnt + 10'd1;
  end

  // Frame wrap pulse and completed-frame counter.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= h_end && v_end;
      if (h_end && v_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Sync, window and position decodes straight from the counters.
  always_comb begin
    vga_hs     = (h_cnt >= H_SYNC_W);
    vga_vs     = (v_cnt >= V_SYNC_W);
    v_win      = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    vga_en     = v_win && (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    data_req   = v_win && (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
    pixel_xpos = data_req ? h_cnt - H_REQ_BEG : '0;
    pixel_ypos = data_req ? v_cnt - V_ACT_BEG : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]  col;
  logic [2:0]  bar;
  logic [15:0] bar_rgb;
  logic        unused_pixel_data;

  assign unused_pixel_data = ^pixel_data;

  // Bar index found by threshold compares rather than a divider.
  always_comb begin
    col = h_cnt - H_ACT_BEG;
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (col >= 10'(i * (H_DISP / 8))) bar = 3'(i);
    end
    case (bar)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
    vga_rgb = vga_en ? bar_rgb : '0;
  end
`else
  // Display data arrives one cycle after its request, aligned with vga_en.
  always_comb begin
    vga_rgb = vga_en ? pixel_data : '0;
  end
`endif

endmodule

// File: tb/tb_vga_driver.sv
// tb_vga_driver: random pixel_data against a position-arithmetic model of
// the raster, using a reduced timing set so hundreds of frames stay short.
module tb_vga_driver;

  localparam int unsigned HS = 3, HB = 2, HD = 16, HF = 2;
  localparam int unsigned VS = 2, VB = 2, VD = 4,  VF = 1;
  localparam int unsigned HT = HS + HB + HD + HF;
  localparam int unsigned VT = VS + VB + VD + VF;
  localparam int unsigned FT = HT * VT;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pixel_data = '0;
  logic        vga_hs, vga_vs, vga_en, data_req, frame_start;
  logic [15:0] vga_rgb;
  logic [9:0]  pixel_xpos, pixel_ypos;
  logic [7:0]  frame_cnt;

  int          checks = 0;
  int          failures = 0;
  int unsigned t;
  int unsigned pulses = 0;
  bit          counting = 1'b0;

  always #5 vga_clk = ~vga_clk;

  vga_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pixel_data(pixel_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_en(vga_en), .vga_rgb(vga_rgb),
    .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // Clock edges elapsed since reset release.
  always @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) t <= 0;
    else            t <= t + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  function automatic logic [15:0] bar_colour(input int unsigned col);
    logic [15:0] tbl [8];
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return tbl[col / (HD / 8)];
  endfunction

  // Model: raster position from elapsed cycles, outputs from window rules.
  always @(negedge vga_clk) begin
    int unsigned p, h, v;
    bit          e_hs, e_vs, e_en, e_req, e_fs, vwin;
    int unsigned e_x, e_y, e_fc;
    logic [15:0] e_rgb;
    if (!sys_rst_n) begin
      e_hs = 0; e_vs = 0; e_en = 0; e_req = 0; e_fs = 0;
      e_x = 0; e_y = 0; e_fc = 0; e_rgb = '0;
    end else begin
      p     = t % FT;
      h     = p % HT;
      v     = p / HT;
      vwin  = (v >= VS + VB) && (v < VS + VB + VD);
      e_hs  = !(h < HS);
      e_vs  = !(v < VS);
      e_en  = vwin && (h >= HS + HB) && (h < HS + HB + HD);
      e_req = vwin && (h + 1 >= HS + HB) && (h + 1 < HS + HB + HD);
      e_x   = e_req ? h + 1 - (HS + HB) : 0;
      e_y   = e_req ? v - (VS + VB) : 0;
`ifdef VGA_TEST_PATTERN_EN
      e_rgb = e_en ? bar_colour(h - (HS + HB)) : 16'h0000;
`else
      e_rgb = e_en ? pixel_data : 16'h0000;
`endif
      e_fs  = (t > 0) && (p == 0);
      e_fc  = (t / FT) % 256;
    end
    chk("vga_hs", vga_hs, e_hs);
    chk("vga_vs", vga_vs, e_vs);
    chk("vga_en", vga_en, e_en);
    chk("data_req", data_req, e_req);
    chk("pixel_xpos", pixel_xpos, e_x);
    chk("pixel_ypos", pixel_ypos, e_y);
    chk("vga_rgb", vga_rgb, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("frame_cnt", frame_cnt, e_fc);

    // Hand-computed anchors for this timing set (line 4 is first active row).
    if (sys_rst_n) begin
      if (t == 2)      chk("pin_hs_low", vga_hs, 0);
      if (t == 3)      chk("pin_hs_high", vga_hs, 1);
      if (t == 95)     chk("pin_req_before", data_req, 0);
      if (t == 96)   begin chk("pin_req_rise", data_req, 1); chk("pin_x0", pixel_xpos, 0);
                           chk("pin_y0", pixel_ypos, 0); chk("pin_en_late", vga_en, 0); end
      if (t == 97)   begin chk("pin_en_rise", vga_en, 1); chk("pin_x1", pixel_xpos, 1); end
      if (t == 111)  begin chk("pin_req_last", data_req, 1); chk("pin_x15", pixel_xpos, 15); end
      if (t == 112)  begin chk("pin_req_end", data_req, 0); chk("pin_en_last", vga_en, 1); end
      if (t == 113)    chk("pin_en_end", vga_en, 0);
      if (t == FT)   begin chk("pin_fs_high", frame_start, 1); chk("pin_fc1", frame_cnt, 1); end
      if (t == FT + 1) chk("pin_fs_low", frame_start, 0);
    end
    if (counting && frame_start) pulses++;
  end

  // Random pixel stream with stretches of constant all-ones.
  initial begin
    forever begin
      @(posedge vga_clk);
      #1;
      pixel_data = ((t % 1000) < 300) ? 16'hFFFF : 16'($urandom);
    end
  end

  initial begin
    int unsigned n;
    sys_rst_n = 1'b0;
    repeat (4) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    repeat (300) @(posedge vga_clk);
    #1;
    // Align to line 5, column 10, then pulse reset mid-cycle for 3 cycles.
    n = (FT + 5 * HT + 10 - (t % FT)) % FT;
    repeat (n) @(posedge vga_clk);
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1 sys_rst_n = 1'b1;
    counting = 1'b1;
    repeat (257 * FT + 5) @(posedge vga_clk);
    @(negedge vga_clk);
    #1;
    counting = 1'b0;
    chk("frame_pulses", pulses, 257);
    chk("frame_cnt_wrap", frame_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
